// File: rtl/alarm_time_editor.sv
// Alarm time editor: turns up/down/next presses into hour/minute edits while program mode is active,
// and commits the edited time to the alarm registers on saved.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | not editing; buttons ignored; displays the committed alarm
// EDIT_HOUR | up/down change the edit hour; next moves to EDIT_MIN
// EDIT_MIN  | up/down change the edit minute; next moves to EDIT_HOUR
module alarm_time_editor #(
    parameter logic [4:0] RESET_HOUR = 5'd0,
    parameter logic [5:0] RESET_MIN  = 6'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active_program_mode,
    input  logic       saved,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_next,
    output logic       button_signal,
    output logic       error_detection,
    output logic [1:0] edit_field,
    output logic [4:0] disp_hour,
    output logic [5:0] disp_min,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       alarm_valid,
    output logic       commit_pulse
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        EDIT_HOUR = 2'b01,
        EDIT_MIN  = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] edit_hour_q, edit_hour_d;
    logic [5:0] edit_min_q, edit_min_d;
    logic [4:0] alarm_hour_q, alarm_hour_d;
    logic [5:0] alarm_min_q, alarm_min_d;
    logic       alarm_valid_q, alarm_valid_d;
    logic       button_q, button_d;
    logic       error_q, error_d;
    logic       commit_q, commit_d;
    logic [1:0] n_btn;

    assign n_btn = {1'b0, btn_up} + {1'b0, btn_down} + {1'b0, btn_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            edit_hour_q   <= RESET_HOUR;
            edit_min_q    <= RESET_MIN;
            alarm_hour_q  <= RESET_HOUR;
            alarm_min_q   <= RESET_MIN;
            alarm_valid_q <= 1'b0;
            button_q      <= 1'b0;
            error_q       <= 1'b0;
            commit_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            edit_hour_q   <= edit_hour_d;
            edit_min_q    <= edit_min_d;
            alarm_hour_q  <= alarm_hour_d;
            alarm_min_q   <= alarm_min_d;
            alarm_valid_q <= alarm_valid_d;
            button_q      <= button_d;
            error_q       <= error_d;
            commit_q      <= commit_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        edit_hour_d   = edit_hour_q;
        edit_min_d    = edit_min_q;
        alarm_hour_d  = alarm_hour_q;
        alarm_min_d   = alarm_min_q;
        alarm_valid_d = alarm_valid_q;
        button_d      = 1'b0;
        error_d       = 1'b0;
        commit_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // Level-sensitive entry: reloads from the alarm registers, including a just-committed value.
                if (active_program_mode) begin
                    edit_hour_d = alarm_hour_q;
                    edit_min_d  = alarm_min_q;
                    state_d     = EDIT_HOUR;
                end
            end
            EDIT_HOUR, EDIT_MIN: begin
                if (saved) begin
                    alarm_hour_d  = edit_hour_q;
                    alarm_min_d   = edit_min_q;
                    alarm_valid_d = 1'b1;
                    commit_d      = 1'b1;
                    state_d       = IDLE;
                end else if (!active_program_mode) begin
                    state_d = IDLE;
                end else if (n_btn > 2'd1) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (n_btn == 2'd1) begin
                    button_d = 1'b1;
                    if (btn_next) begin
                        state_d = (state_q == EDIT_HOUR) ? EDIT_MIN : EDIT_HOUR;
                    end else if (state_q == EDIT_HOUR) begin
                        if (btn_up) edit_hour_d = (edit_hour_q == 5'd23) ? 5'd0 : edit_hour_q + 5'd1;
                        else        edit_hour_d = (edit_hour_q == 5'd0) ? 5'd23 : edit_hour_q - 5'd1;
                    end else begin
                        if (btn_up) edit_min_d = (edit_min_q == 6'd59) ? 6'd0 : edit_min_q + 6'd1;
                        else        edit_min_d = (edit_min_q == 6'd0) ? 6'd59 : edit_min_q - 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        edit_field = 2'b00;
        disp_hour  = alarm_hour_q;
        disp_min   = alarm_min_q;
        if (state_q == EDIT_HOUR || state_q == EDIT_MIN) begin
            edit_field = (state_q == EDIT_HOUR) ? 2'b01 : 2'b10;
            disp_hour  = edit_hour_q;
            disp_min   = edit_min_q;
        end
    end

    assign alarm_hour      = alarm_hour_q;
    assign alarm_min       = alarm_min_q;
    assign alarm_valid     = alarm_valid_q;
    assign button_signal   = button_q;
    assign error_detection = error_q;
    assign commit_pulse    = commit_q;

endmodule
